// File: rtl/pipelined_memory.sv
// rtl/pipelined_memory.sv - zero-initialised single-cycle memory with fetch and data ports
// Optional per-byte even parity enabled by defining MEMORY_PARITY_EN.
module pipelined_memory #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 8,
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  output logic                    o_init_done,
  input  logic                    i_f_valid,
  input  logic [ADDR_WIDTH-1:0]   i_f_addr,
  output logic                    o_f_valid,
  output logic [INSTR_WIDTH-1:0]  o_f_data,
  output logic                    o_f_perr,
  input  logic                    i_d_valid,
  output logic                    o_d_ready,
  input  logic                    i_d_we,
  input  logic [DATA_WIDTH/8-1:0] i_d_be,
  input  logic [ADDR_WIDTH-1:0]   i_d_addr,
  input  logic [DATA_WIDTH-1:0]   i_d_data,
  output logic                    o_d_valid,
  output logic [DATA_WIDTH-1:0]   o_d_data,
  output logic                    o_d_err,
  output logic                    o_d_perr
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IOFF  = $clog2(INSTR_WIDTH / 8);
  localparam int LANES = DATA_WIDTH / INSTR_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state;
  logic [AW-1:0]         init_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  run;
  logic [ADDR_WIDTH-1:0] d_wfull, f_wfull;
  logic                  d_in, f_in;
  logic [AW-1:0]         d_idx, f_idx;
  logic [LW-1:0]         lane;
  logic                  d_acc, d_wr, f_acc;
  logic [DATA_WIDTH-1:0] wr_word, f_word;
  logic [INSTR_WIDTH-1:0] f_lane;
  logic                  d_perr_now, f_perr_now;

  logic                   d_valid_q, d_err_q, d_perr_q;
  logic [DATA_WIDTH-1:0]  d_data_q;
  logic                   f_valid_q, f_perr_q;
  logic [INSTR_WIDTH-1:0] f_data_q;

  assign run     = (state == S_RUN);
  assign d_wfull = i_d_addr >> OFF;
  assign f_wfull = i_f_addr >> OFF;
  assign d_in    = (d_wfull < DEPTH_A);
  assign f_in    = (f_wfull < DEPTH_A);
  assign d_idx   = d_wfull[AW-1:0];
  assign f_idx   = f_wfull[AW-1:0];
  assign lane    = LW'((i_f_addr >> IOFF) & ADDR_WIDTH'(LANES - 1));
  assign d_acc   = run & i_d_valid & ~i_rst;
  assign d_wr    = d_acc & i_d_we & d_in;
  assign f_acc   = run & i_f_valid & ~i_rst;

  always_comb begin
    wr_word = mem[d_idx];
    for (int b = 0; b < NB; b++)
      if (i_d_be[b]) wr_word[b*8 +: 8] = i_d_data[b*8 +: 8];
  end

  // A fetch hitting the word being written this cycle sees the merged value.
  assign f_word = (d_wr && (d_idx == f_idx)) ? wr_word : mem[f_idx];
  assign f_lane = f_word[lane*INSTR_WIDTH +: INSTR_WIDTH];

`ifdef MEMORY_PARITY_EN
  localparam int IB = INSTR_WIDTH / 8;

  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] wr_par, f_par, f_calc;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] w);
    for (int b = 0; b < NB; b++) byte_par[b] = ^w[b*8 +: 8];
  endfunction

  always_comb begin
    wr_par = par[d_idx];
    for (int b = 0; b < NB; b++)
      if (i_d_be[b]) wr_par[b] = ^i_d_data[b*8 +: 8];
  end

  assign f_par      = (d_wr && (d_idx == f_idx)) ? wr_par : par[f_idx];
  assign f_calc     = byte_par(f_word) ^ f_par;
  assign f_perr_now = |f_calc[lane*IB +: IB];
  assign d_perr_now = |(byte_par(mem[d_idx]) ^ par[d_idx]);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state == S_INIT) par[init_cnt] <= '0;
      else if (d_wr)       par[d_idx]    <= wr_par;
    end
  end
`else
  assign d_perr_now = 1'b0;
  assign f_perr_now = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state == S_INIT) mem[init_cnt] <= '0;
      else if (d_wr)       mem[d_idx]    <= wr_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      d_valid_q <= 1'b0;
      d_data_q  <= '0;
      d_err_q   <= 1'b0;
      d_perr_q  <= 1'b0;
      f_valid_q <= 1'b0;
      f_data_q  <= '0;
      f_perr_q  <= 1'b0;
    end else begin
      if (state == S_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == AW'(DEPTH - 1)) state <= S_RUN;
      end
      d_valid_q <= d_acc;
      d_data_q  <= (d_acc && !i_d_we && d_in) ? mem[d_idx] : '0;
      d_err_q   <= d_acc & ~d_in;
      d_perr_q  <= d_acc & ~i_d_we & d_in & d_perr_now;
      f_valid_q <= f_acc;
      f_data_q  <= (f_acc && f_in) ? f_lane : '0;
      f_perr_q  <= f_acc & f_in & f_perr_now;
    end
  end

  // Reset silences every output immediately, not just after the next edge.
  assign o_init_done = run & ~i_rst;
  assign o_d_ready   = run & ~i_rst;
  assign o_d_valid   = d_valid_q & ~i_rst;
  assign o_d_data    = d_data_q & {DATA_WIDTH{~i_rst}};
  assign o_d_err     = d_err_q & ~i_rst;
  assign o_d_perr    = d_perr_q & ~i_rst;
  assign o_f_valid   = f_valid_q & ~i_rst;
  assign o_f_data    = f_data_q & {INSTR_WIDTH{~i_rst}};
  assign o_f_perr    = f_perr_q & ~i_rst;

endmodule

// File: tb/tb_pipelined_memory.sv
// tb/tb_pipelined_memory.sv - directed and random checks of pipelined_memory against a word-array model
module tb_pipelined_memory;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_init_done;
  logic        i_f_valid = 1'b0;
  logic [31:0] i_f_addr = '0;
  logic        o_f_valid;
  logic [7:0]  o_f_data;
  logic        o_f_perr;
  logic        i_d_valid = 1'b0;
  logic        o_d_ready;
  logic        i_d_we = 1'b0;
  logic [3:0]  i_d_be = '0;
  logic [31:0] i_d_addr = '0;
  logic [31:0] i_d_data = '0;
  logic        o_d_valid;
  logic [31:0] o_d_data;
  logic        o_d_err;
  logic        o_d_perr;

  pipelined_memory #(.DATA_WIDTH(32), .INSTR_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .o_init_done(o_init_done),
    .i_f_valid(i_f_valid), .i_f_addr(i_f_addr), .o_f_valid(o_f_valid),
    .o_f_data(o_f_data), .o_f_perr(o_f_perr),
    .i_d_valid(i_d_valid), .o_d_ready(o_d_ready), .i_d_we(i_d_we), .i_d_be(i_d_be),
    .i_d_addr(i_d_addr), .i_d_data(i_d_data), .o_d_valid(o_d_valid),
    .o_d_data(o_d_data), .o_d_err(o_d_err), .o_d_perr(o_d_perr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model [16];
  int          bad_word = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_done"}, 32'(o_init_done), 0);
    chk({tag, "_rdy"},  32'(o_d_ready), 0);
    chk({tag, "_dv"},   32'(o_d_valid), 0);
    chk({tag, "_dd"},   o_d_data, 0);
    chk({tag, "_fv"},   32'(o_f_valid), 0);
    chk({tag, "_fd"},   32'(o_f_data), 0);
  endtask

  // One clock of traffic: expected response derived from the word-array model.
  task automatic req(input string tag, input logic dv, input logic we, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic fv, input logic [31:0] fa);
    int          wi, fi;
    logic [31:0] e_dd, e_fd;
    logic        e_err, e_dp, e_fp;
    wi = int'(a >> 2);
    fi = int'(fa >> 2);
    e_dd = '0; e_err = 1'b0; e_dp = 1'b0; e_fd = '0; e_fp = 1'b0;
    if (dv) begin
      e_err = (wi >= 16);
      if (!we && wi < 16) begin
        e_dd = model[wi];
        e_dp = (wi == bad_word);
      end
      if (we && wi < 16)
        for (int b = 0; b < 4; b++)
          if (be[b]) model[wi][b*8 +: 8] = d[b*8 +: 8];
    end
    if (fv && fi < 16) begin
      e_fd = (model[fi] >> (8 * int'(fa[1:0]))) & 32'hFF;
      e_fp = (fi == bad_word);
    end
    i_d_valid = dv; i_d_we = we; i_d_be = be; i_d_addr = a; i_d_data = d;
    i_f_valid = fv; i_f_addr = fa;
    step();
    chk({tag, "_dv"},   32'(o_d_valid), 32'(dv));
    chk({tag, "_dd"},   o_d_data, e_dd);
    chk({tag, "_derr"}, 32'(o_d_err), 32'(e_err));
    chk({tag, "_dperr"}, 32'(o_d_perr), 32'(e_dp));
    chk({tag, "_fv"},   32'(o_f_valid), 32'(fv));
    chk({tag, "_fd"},   32'(o_f_data), e_fd);
    chk({tag, "_fperr"}, 32'(o_f_perr), 32'(e_fp));
  endtask

  task automatic idle(input string tag);
    req(tag, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Counts INIT cycles after release; requests issued early in INIT must be ignored.
  task automatic wait_init(input string tag);
    int n = 0;
    while (!o_init_done && n < 200) begin
      i_d_valid = (n < 3); i_d_we = 1'b1; i_d_be = 4'hF; i_d_addr = 32'h0; i_d_data = 32'hFFFF_FFFF;
      i_f_valid = (n < 3); i_f_addr = 32'h0;
      step();
      n++;
      if (n <= 4) begin
        chk({tag, "_init_dv"}, 32'(o_d_valid), 0);
        chk({tag, "_init_fv"}, 32'(o_f_valid), 0);
      end
    end
    i_d_valid = 1'b0; i_f_valid = 1'b0;
    chk({tag, "_init_cycles"}, n, 16);
    chk({tag, "_ready"}, 32'(o_d_ready), 1);
    clear_model();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    step();
    step();
    chk_quiet("rst_hold");
    i_rst = 1'b0;
    wait_init("por");

    req("rd_3c", 1, 0, 4'h0, 32'h3C, 32'h0, 0, 32'h0);
    req("wr_dead", 1, 1, 4'hF, 32'h8, 32'hDEADBEEF, 0, 32'h0);
    req("wr_aa", 1, 1, 4'h1, 32'h8, 32'h000000AA, 0, 32'h0);
    req("rd_8", 1, 0, 4'h0, 32'h8, 32'h0, 0, 32'h0);
    chk("rd_8_value", o_d_data, 32'hDEADBEAA);
    req("f_8", 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h8);
    chk("f_8_value", 32'(o_f_data), 32'hAA);
    req("f_9", 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'h9);
    req("f_a", 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hA);
    req("f_b", 0, 0, 4'h0, 32'h0, 32'h0, 1, 32'hB);
    chk("f_b_value", 32'(o_f_data), 32'hDE);
    req("wr_oob", 1, 1, 4'hF, 32'h40, 32'h12345678, 0, 32'h0);
    chk("wr_oob_err", 32'(o_d_err), 1);
    req("rd_0", 1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h40);
    req("rd_oob", 1, 0, 4'h0, 32'h44, 32'h0, 0, 32'h0);
    req("wr_fwd", 1, 1, 4'hF, 32'h4, 32'h11223344, 1, 32'h4);
    chk("wr_fwd_value", 32'(o_f_data), 32'h44);
    req("wr_be0", 1, 1, 4'h0, 32'h4, 32'hFFFFFFFF, 1, 32'h7);
    req("rd_mis", 1, 0, 4'h0, 32'hB, 32'h0, 1, 32'h6);
    idle("idle1");

`ifdef MEMORY_PARITY_EN
    dut.mem[2] = dut.mem[2] ^ 32'h1;
    model[2] = model[2] ^ 32'h1;
    bad_word = 2;
    req("perr_rd", 1, 0, 4'h0, 32'h8, 32'h0, 1, 32'h8);
    chk("perr_flag", 32'(o_d_perr), 1);
    bad_word = -1;
    req("perr_fix", 1, 1, 4'hF, 32'h8, 32'hDEADBEAA, 0, 32'h0);
`endif

    for (int i = 0; i < 300; i++) begin
      req("rnd", ($urandom % 4) != 0, 1'($urandom), 4'($urandom),
          (32'($urandom_range(0, 20)) << 2) | 32'($urandom % 4), $urandom,
          1'($urandom), 32'($urandom_range(0, 32'h53)));
    end
    for (int i = 0; i < 16; i++) req("sweep", 1, 0, 4'h0, 32'(i) << 2, 32'h0, 1, 32'(i) << 2);

    req("pend", 1, 0, 4'h0, 32'h8, 32'h0, 1, 32'h8);
    i_rst = 1'b1;
    #1;
    chk_quiet("rst_async_view");
    step();
    chk_quiet("rst_run");
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    i_rst = 1'b1;
    step();
    chk_quiet("rst_mid_init");
    i_rst = 1'b0;
    wait_init("reinit");
    req("rd_8_zero", 1, 0, 4'h0, 32'h8, 32'h0, 1, 32'h9);
    req("rd_4_zero", 1, 0, 4'h0, 32'h4, 32'h0, 1, 32'h4);
    idle("idle_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_memory.md
PIPELINED_MEMORY -- requirements
Module: pipelined_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter INSTR_WIDTH, default 8, fetch-port instruction width (multiple of 8, divides DATA_WIDTH).
REQ-003 SHALL have parameter DEPTH, default 1024, number of words (power of two, >=2).
REQ-004 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-005 SHALL have ports, in this order:
  i_clk  input  1  sole clock, all logic on rising edge
  i_rst  input  1  synchronous active-high reset
  o_init_done  output  1  high once zero-fill sweep completes
  i_f_valid  input  1  fetch request
  i_f_addr  input  ADDR_WIDTH  fetch byte address, INSTR_WIDTH-aligned
  o_f_valid  output  1  fetch response valid
  o_f_data  output  INSTR_WIDTH  fetched instruction
  o_f_perr  output  1  fetch parity error
  i_d_valid  input  1  data request
  o_d_ready  output  1  data port can accept
  i_d_we  input  1  1=write, 0=read
  i_d_be  input  DATA_WIDTH/8  byte enables for writes
  i_d_addr  input  ADDR_WIDTH  data byte address, word-aligned
  i_d_data  input  DATA_WIDTH  write data
  o_d_valid  output  1  data response valid (reads and writes)
  o_d_data  output  DATA_WIDTH  read data (0 for writes)
  o_d_err  output  1  address out of range
  o_d_perr  output  1  data parity error
REQ-006 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-007 SHALL implement states INIT and RUN; INIT writes zero (and correct parity) to word k in cycle k, k=0..DEPTH-1, then enters RUN; o_init_done=1 and o_d_ready=1 only in RUN.
REQ-008 SHALL ignore fetch and data requests in INIT (no response, no write).
REQ-009 SHALL accept a data request on cycle N when i_d_valid&&o_d_ready; o_d_valid high exactly in cycle N+1 for one cycle per accepted request; back-to-back requests every cycle supported.
REQ-010 SHALL accept a fetch request on cycle N when i_f_valid in RUN; o_f_valid high in cycle N+1; o_f_data is lane i_f_addr[log2(DATA_WIDTH/8)-1:log2(INSTR_WIDTH/8)] of word i_f_addr>>log2(DATA_WIDTH/8).
REQ-011 SHALL decode word index as addr>>log2(DATA_WIDTH/8); addresses with word index >= DEPTH SHALL set o_d_err=1 with the response, suppress the write, return o_d_data=0; fetch out-of-range returns 0.
REQ-012 SHALL update on writes only bytes with i_d_be[b]=1; i_d_be=0 is a legal no-op write that still responds.
REQ-013 SHALL, for a fetch in the same cycle as a write to the same word, return the post-write (merged) data.
REQ-014 SHALL hold o_d_data, o_f_data, error flags at 0 whenever the matching valid is 0.
REQ-015 SHALL ignore low address bits below the access width (no misalignment fault).

Reset
REQ-016 SHALL, while i_rst=1, drive o_init_done=0, o_d_ready=0, o_f_valid=0, o_d_valid=0, all data/error outputs 0.
REQ-017 SHALL on reset (including mid-INIT or mid-RUN) discard any pending response, restart INIT at word 0; memory contents are rewritten to zero.

Configuration
REQ-018 SHALL, with MEMORY_PARITY_EN defined, store one even-parity bit per byte, check on every read/fetch, and raise o_d_perr/o_f_perr with the response if any read byte mismatches (full word for data, covering bytes for fetch).
REQ-019 SHALL, without MEMORY_PARITY_EN, store no parity bits and tie o_d_perr and o_f_perr to 0.

Verification
REQ-020 Reset, DEPTH=16 -> o_init_done rises after 16 cycles in RUN; read of addr 0x3C returns 0x00000000, o_d_err=0.
REQ-021 Write 0xDEADBEEF be=4'b1111 addr 0x8, then write 0x000000AA be=4'b0001 addr 0x8, read 0x8 -> 0xDEADBEAA, one response per request, latency 1.
REQ-022 Fetch addrs 0x8..0xB after REQ-021 -> o_f_data 0xAA,0xBE,0xAD,0xDE on consecutive cycles.
REQ-023 DEPTH=16, write 0x12345678 to addr 0x40 -> o_d_err=1, no memory change; subsequent read 0x0 unaffected.
REQ-024 Same-cycle write 0x11223344 addr 0x4 and fetch addr 0x4 -> o_f_data=0x44; assert i_rst mid-INIT at cycle 5 -> sweep restarts, o_init_done after 16 cycles post-release.
REQ-025 MEMORY_PARITY_EN: force-flip a stored bit in word 2, read 0x8 -> o_d_perr=1; without macro o_d_perr stays 0.
